// File: rtl/sram_pkg.sv
// Shared types and constants for the 16-bit asynchronous SRAM bridge.
package sram_pkg;

  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_ADDR_W = 18;

  // One 32-bit word is moved as a low half (LO) followed by a high half (HI).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } sram_state_t;

endpackage

// File: rtl/sram_controller.sv
// Bridges 32-bit MEM-stage word requests onto a 16-bit asynchronous SRAM as two
// half-word accesses, each held on the pins for WAIT_CYCLES cycles. ready is low
// while a request is pending or in flight so the pipeline can freeze.
// Optional feature macro: SRAM_ADDR_OFFSET_EN (subtract ADDR_BASE from the address).
module sram_controller
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 4,
  parameter int ADDR_BASE   = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WAIT_CYCLES - 1);

  sram_state_t            r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_is_wr;
  logic [16:0]            r_word;
  logic [31:0]            r_wdata;
  logic [31:0]            r_rdata;

  logic                   w_req;
  logic                   w_last;
  logic [31:0]            w_offset;
  logic                   w_dq_en;
  logic [SRAM_DATA_W-1:0] w_dq_out;
  logic                   w_unused;

`ifdef SRAM_ADDR_OFFSET_EN
  assign w_offset = address - 32'(ADDR_BASE);
  assign w_unused = ^{w_offset[31:19], w_offset[1:0]};
`else
  assign w_offset = address;
  assign w_unused = ^{w_offset[31:19], w_offset[1:0], 32'(ADDR_BASE)};
`endif

  assign w_req  = wr_en | rd_en;
  assign w_last = (r_cnt == C_LAST);

  // FSM, hold counter, request latch and half-word read capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_is_wr <= 1'b0;
      r_word  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state <= LO;
            r_cnt   <= '0;
            // Write wins when both requests are raised together.
            r_is_wr <= wr_en;
            r_word  <= w_offset[18:2];
            r_wdata <= write_data;
          end
        end
        LO: begin
          if (w_last) begin
            r_state <= HI;
            r_cnt   <= '0;
            if (!r_is_wr) r_rdata[15:0] <= SRAM_DQ;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        HI: begin
          if (w_last) begin
            r_state <= DONE;
            r_cnt   <= '0;
            if (!r_is_wr) r_rdata[31:16] <= SRAM_DQ;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // SRAM pin decode from the current state; address parks at 0 outside an access.
  always_comb begin
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    w_dq_en   = 1'b0;
    w_dq_out  = '0;
    case (r_state)
      LO: begin
        SRAM_ADDR = {r_word, 1'b0};
        if (r_is_wr) begin
          SRAM_WE_N = 1'b0;
          w_dq_en   = 1'b1;
          w_dq_out  = r_wdata[15:0];
        end
      end
      HI: begin
        SRAM_ADDR = {r_word, 1'b1};
        if (r_is_wr) begin
          SRAM_WE_N = 1'b0;
          w_dq_en   = 1'b1;
          w_dq_out  = r_wdata[31:16];
        end
      end
      default: begin
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
      end
    endcase
  end

  assign SRAM_DQ   = w_dq_en ? w_dq_out : {SRAM_DATA_W{1'bz}};
  assign ready     = ((r_state == IDLE) && !w_req) || (r_state == DONE);
  assign read_data = r_rdata;

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: doc/sram_controller.md
# sram_controller

Bridges the MEM stage's 32-bit word requests to the board's 16-bit asynchronous SRAM. Every access becomes two back-to-back 16-bit half-word accesses, each held for a fixed number of cycles. While an access is in flight, `ready` stays low; the top level combines it into `memFreeze` to stall the IF, ID, EXE and MEM pipeline registers. The block sits directly below MEM_Stage and owns all SRAM pins.

## Interface
Parameters:
- `WAIT_CYCLES`, 4, cycles each 16-bit half access is held on the pins; legal range ≥1.
- `ADDR_BASE`, 1024, byte address of data memory start; used only under the macro.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `wr_en` in 1: write request; held by MEM stage until `ready`.
- `rd_en` in 1: read request; held by MEM stage until `ready`.
- `address` in 32: byte address; bits [1:0] ignored.
- `write_data` in 32: store value.
- `read_data` out 32: last read word, registered.
- `ready` out 1: low while a request is pending or in flight.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` out 18: SRAM half-word address.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N` out 1: all tied to 0.
- `SRAM_WE_N` out 1: SRAM write strobe, active low.

## Operation
- **States:** IDLE, LO, HI, DONE.
- **Cycle counter:** width `$clog2(WAIT_CYCLES)` with a minimum of 1. It clears on every state entry.
- **IDLE:**
  - If `wr_en | rd_en`, go to LO and latch op type, word index and `write_data`.
  - `wr_en` has priority if both are high.
- **LO:**
  - `SRAM_ADDR = {word, 1'b0}`.
  - After `WAIT_CYCLES` cycles, go to HI.
  - On a read, capture `SRAM_DQ` into `read_data[15:0]` on the last LO cycle.
- **HI:**
  - `SRAM_ADDR = {word, 1'b1}`.
  - After `WAIT_CYCLES` cycles, go to DONE.
  - On a read, capture `SRAM_DQ` into `read_data[31:16]` on the last HI cycle.
- **DONE:** `ready = 1` for exactly one cycle, then go to IDLE unconditionally. The pipeline advances on this edge, so a new request is seen in IDLE on the next cycle.
- **`ready`:** combinational.
  - 1 in IDLE with no request.
  - 1 in DONE.
  - 0 otherwise.
- **Write phase:**
  - `SRAM_WE_N = 0` during LO/HI.
  - `SRAM_DQ` is driven with `wdata[15:0]` in LO and `wdata[31:16]` in HI.
- **Read phase and IDLE/DONE:**
  - `SRAM_WE_N = 1`.
  - `SRAM_DQ` is high-Z.
- **Word index:** the 17-bit `offset[18:2]`.
- **`read_data`:**
  - Holds its value across writes and idle cycles.
  - Updates only on read captures.
- **Request changes mid-access:** if the MEM stage drops or changes the request after leaving IDLE, the block ignores it because the latched values are used.
- **Reset:**
  - Honoured in any state, including mid-access.
  - Next state IDLE.
  - `read_data = 0`, `SRAM_WE_N = 1`, `SRAM_DQ` high-Z, `SRAM_ADDR = 0`.
  - `ready` follows the IDLE rule.

## Timing
- **Request timeline:** a request seen in IDLE at cycle 0 gives:
  - LO for cycles 1..W.
  - HI for cycles W+1..2W.
  - DONE in cycle 2W+1.
- **Stall length:** `ready = 0` for 2W+1 cycles. With W=4, this is 9 stall cycles and `ready` is high in cycle 9.
- **Read data valid:** `read_data` is valid in DONE and stays valid afterwards.
- **Back-to-back requests:** the minimum spacing is 2W+2 cycles between request starts.

## Configuration
- **Macro:** `SRAM_ADDR_OFFSET_EN`.
- **Defined:** `offset = address - ADDR_BASE`, so byte address 1024 maps to `SRAM_ADDR` 0/1.
- **Undefined:**
  - `offset = address`; `ADDR_BASE` is unused.
  - Byte address 1024 maps to `SRAM_ADDR` 512/513.

## Structure
- **Shared package `sram_pkg`:**
  - State enum `sram_state_t` (IDLE, LO, HI, DONE).
  - Constants `SRAM_DATA_W=16` and `SRAM_ADDR_W=18`.
- **No sub-module:** the tristate driver and the capture logic are inline.

## Test plan
- Reset asserted mid-HI of a write → next cycle: IDLE, `SRAM_WE_N = 1`, DQ high-Z, `read_data = 0`.
- Write 0xDEADBEEF to address 1028 (macro on, W=4):
  - cycles 1-4: `SRAM_ADDR = 2`, DQ = 0xBEEF, `WE_N = 0`.
  - cycles 5-8: `SRAM_ADDR = 3`, DQ = 0xDEAD, `WE_N = 0`.
  - cycle 9: `ready = 1`.
- Read 1028 with an SRAM model holding the above → `read_data = 0xDEADBEEF` in cycle 9; `ready` low in cycles 0-8.
- Simultaneous `wr_en` and `rd_en` at address 1024 → write performed and `read_data` unchanged.
- Back-to-back read then write with requests held → second access enters LO exactly 2 cycles after the first one's DONE edge (i.e. IDLE sits one cycle between them); no lost request.
- Macro off: read address 1024 → `SRAM_ADDR` 512 then 513.
